l1d_way_resolve_ctrl: RTL and testbench
=======================================

// Module: l1d_way_resolve_ctrl
// PURPOSE
//  Sequencing controller that sits after the L1D tag-compare stage. Per lookup it classifies
//  the per-way hit vector as single hit, miss or multi-hit. Misses go to a refill handshake
//  with a per-set round-robin victim. Multi-hits are recovered by invalidating all hitting
//  ways, then refilling. One lookup is in flight at a time. Results go to the load/store pipe
//  via a valid/ready response.
// PARAMETERS
//  WAYS  4   associativity; power of two, >=2; WAY_W = $clog2(WAYS)
//  SETS  64  number of sets; power of two, >=2; SET_W = $clog2(SETS)
//  CNT_W 8   width of saturating multi-hit event counter
// PORTS
//  core_clock_i      in   1      core clock, all state on rising edge
//  core_reset_n_i    in   1      asynchronous, active-low reset
//  lookup_valid_i    in   1      lookup request; set/hit_vec valid with it
//  lookup_ready_o    out  1      controller can accept a lookup (IDLE only)
//  lookup_set_i      in   SET_W  set index of lookup
//  hit_vec_i         in   WAYS   per-way tag-match & valid vector
//  resp_valid_o      out  1      response valid
//  resp_ready_i      in   1      consumer accepts response
//  resp_hit_o        out  1      1 = clean single hit, 0 = line was refilled
//  resp_way_o        out  WAY_W  way holding the line
//  inval_valid_o     out  1      invalidate request to tag array
//  inval_set_o       out  SET_W  set to invalidate in
//  inval_ways_o      out  WAYS   mask of ways to invalidate
//  inval_ack_i       in   1      tag array completed invalidate
//  refill_req_o      out  1      refill request to memory side
//  refill_set_o      out  SET_W  set being refilled
//  refill_way_o      out  WAY_W  victim way being refilled
//  refill_ack_i      in   1      refill written into data/tag arrays
//  multihit_cnt_o    out  CNT_W  count of multi-hit events, saturating
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; all outputs 0 except lookup_ready_o=1.
//   - All per-set victim pointers =0; multihit_cnt_o=0.
//   - Reset mid-operation abandons the lookup; no response is produced.
//  States: IDLE, INVAL, REFILL, RESP. All outputs are registered or decoded from state only.
//  IDLE: lookup_ready_o=1. On lookup_valid_i, capture set and hit_vec, then classify:
//   - popcount==1 -> way=index of set bit, hit=1 -> RESP. resp_valid 1 cycle after accept.
//   - popcount==0 -> way=victim_ptr[set], hit=0 -> REFILL.
//   - popcount>=2 -> inval_ways_o=hit_vec, multihit_cnt_o+=1 (hold at 2^CNT_W-1) -> INVAL.
//  INVAL: inval_valid_o=1 held until inval_ack_i is sampled.
//   - On ack: way=victim_ptr[set], hit=0 -> REFILL.
//  REFILL: refill_req_o=1 with stable refill_set_o/refill_way_o until refill_ack_i is sampled.
//   - Ack is legal in the first REFILL cycle.
//   - On ack: victim_ptr[set] += 1 (wraps WAYS-1 -> 0) -> RESP.
//  RESP: resp_valid_o=1; resp_hit_o/resp_way_o stable until resp_ready_i is sampled.
//   - On handshake -> IDLE. Next lookup can be accepted the cycle after.
//  Acks sampled in any other state are ignored. Lookups outside IDLE are not accepted;
//  lookup_valid_i may be held. Victim pointers change only on refill_ack_i.
//  Latencies:
//   - Hit: 1 cycle to resp_valid_o.
//   - Miss: 1 + refill wait + 1.
//   - Multi-hit: adds the invalidate wait.
// TESTING
//  1. Reset then lookup set=5 hit_vec=4'b0100 -> next cycle resp_valid=1, hit=1, way=2;
//     ptr[5] unchanged.
//  2. Miss set=3 x5, each acked 2 cycles after req -> refill_way 0,1,2,3,0; every resp hit=0.
//  3. Multi-hit set=7 hit_vec=4'b1010 -> inval_ways=1010, cnt=1; after ack refill_way=0,
//     then resp hit=0 way=0.
//  4. 300 multi-hits with CNT_W=8 -> multihit_cnt_o saturates at 255.
//  5. resp_ready_i low for 4 cycles -> resp fields stable, lookup_ready_o=0; accept resumes
//     after handshake.
//  6. Reset asserted during REFILL -> refill_req_o=0 immediately, state IDLE; all ptrs and
//     cnt read 0 on the next miss/multi-hit.

Source files
------------

// File: rtl/l1d_way_resolve_ctrl.sv
// L1D way-resolution controller: classifies a tag-compare hit vector and sequences
// multi-hit invalidation, miss refill with per-set round-robin victims, and the response.
module l1d_way_resolve_ctrl #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 64,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned WAY_W = $clog2(WAYS),
  localparam int unsigned SET_W = $clog2(SETS)
) (
  input  logic             core_clock_i,
  input  logic             core_reset_n_i,
  input  logic             lookup_valid_i,
  output logic             lookup_ready_o,
  input  logic [SET_W-1:0] lookup_set_i,
  input  logic [WAYS-1:0]  hit_vec_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_hit_o,
  output logic [WAY_W-1:0] resp_way_o,
  output logic             inval_valid_o,
  output logic [SET_W-1:0] inval_set_o,
  output logic [WAYS-1:0]  inval_ways_o,
  input  logic             inval_ack_i,
  output logic             refill_req_o,
  output logic [SET_W-1:0] refill_set_o,
  output logic [WAY_W-1:0] refill_way_o,
  input  logic             refill_ack_i,
  output logic [CNT_W-1:0] multihit_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INVAL  = 2'd1,
    S_REFILL = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e             state_q;
  logic [SET_W-1:0]   set_q;
  logic [WAY_W-1:0]   way_q;
  logic               hit_q;
  logic [WAYS-1:0]    inval_ways_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WAY_W-1:0]   victim_ptr_q [SETS];

  logic [WAY_W:0]     hit_cnt;
  logic [WAY_W-1:0]   hit_idx;
  logic               single_hit;
  logic               no_hit;
  logic [WAY_W-1:0]   lookup_victim;
  logic [WAY_W-1:0]   held_victim;
  logic               lookup_fire;
  logic               refill_done;

  // Popcount and index of the (last) set bit; the index is only used when exactly one is set.
  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (hit_vec_i[i]) begin
        hit_cnt = hit_cnt + (WAY_W+1)'(1);
        hit_idx = WAY_W'(i);
      end
    end
  end

  assign single_hit    = (hit_cnt == (WAY_W+1)'(1));
  assign no_hit        = (hit_cnt == '0);
  assign lookup_victim = victim_ptr_q[lookup_set_i];
  assign held_victim   = victim_ptr_q[set_q];
  assign lookup_fire   = (state_q == S_IDLE) && lookup_valid_i;
  assign refill_done   = (state_q == S_REFILL) && refill_ack_i;

  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_q      <= S_IDLE;
      set_q        <= '0;
      way_q        <= '0;
      hit_q        <= 1'b0;
      inval_ways_q <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lookup_fire) begin
            set_q <= lookup_set_i;
            if (single_hit) begin
              way_q   <= hit_idx;
              hit_q   <= 1'b1;
              state_q <= S_RESP;
            end else if (no_hit) begin
              way_q   <= lookup_victim;
              hit_q   <= 1'b0;
              state_q <= S_REFILL;
            end else begin
              inval_ways_q <= hit_vec_i;
              hit_q        <= 1'b0;
              if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
              state_q <= S_INVAL;
            end
          end
        end
        S_INVAL: begin
          if (inval_ack_i) begin
            // Victim is read after the invalidate so the refill uses the current pointer.
            way_q        <= held_victim;
            inval_ways_q <= '0;
            state_q      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (refill_ack_i) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        victim_ptr_q[s] <= '0;
      end
    end else if (refill_done) begin
      victim_ptr_q[set_q] <= victim_ptr_q[set_q] + WAY_W'(1);
    end
  end

  assign lookup_ready_o = (state_q == S_IDLE);
  assign inval_valid_o  = (state_q == S_INVAL);
  assign refill_req_o   = (state_q == S_REFILL);
  assign resp_valid_o   = (state_q == S_RESP);
  assign resp_hit_o     = hit_q;
  assign resp_way_o     = way_q;
  assign inval_set_o    = set_q;
  assign inval_ways_o   = inval_ways_q;
  assign refill_set_o   = set_q;
  assign refill_way_o   = way_q;
  assign multihit_cnt_o = cnt_q;

endmodule

// File: tb/tb_l1d_way_resolve_ctrl.sv
// Directed, table-driven bench for l1d_way_resolve_ctrl (WAYS=4, SETS=64, CNT_W=8).
module tb_l1d_way_resolve_ctrl;

  logic       clk;
  logic       rst_n;
  logic       lookup_valid_i;
  logic       lookup_ready_o;
  logic [5:0] lookup_set_i;
  logic [3:0] hit_vec_i;
  logic       resp_valid_o;
  logic       resp_ready_i;
  logic       resp_hit_o;
  logic [1:0] resp_way_o;
  logic       inval_valid_o;
  logic [5:0] inval_set_o;
  logic [3:0] inval_ways_o;
  logic       inval_ack_i;
  logic       refill_req_o;
  logic [5:0] refill_set_o;
  logic [1:0] refill_way_o;
  logic       refill_ack_i;
  logic [7:0] multihit_cnt_o;

  int checks = 0;
  int errors = 0;

  l1d_way_resolve_ctrl #(.WAYS(4), .SETS(64), .CNT_W(8)) dut (
    .core_clock_i   (clk),
    .core_reset_n_i (rst_n),
    .lookup_valid_i (lookup_valid_i),
    .lookup_ready_o (lookup_ready_o),
    .lookup_set_i   (lookup_set_i),
    .hit_vec_i      (hit_vec_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_hit_o     (resp_hit_o),
    .resp_way_o     (resp_way_o),
    .inval_valid_o  (inval_valid_o),
    .inval_set_o    (inval_set_o),
    .inval_ways_o   (inval_ways_o),
    .inval_ack_i    (inval_ack_i),
    .refill_req_o   (refill_req_o),
    .refill_set_o   (refill_set_o),
    .refill_way_o   (refill_way_o),
    .refill_ack_i   (refill_ack_i),
    .multihit_cnt_o (multihit_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] set;
    logic [3:0] hv;
    int         inv_dly;
    int         ref_dly;
    int         rsp_dly;
    logic       exp_hit;
    logic [1:0] exp_way;
    logic [3:0] exp_inval;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete lookup through to its response handshake, checking every phase.
  task automatic run(input vec_t v);
    chk("ready_before_lookup", lookup_ready_o, 1);
    lookup_valid_i = 1'b1;
    lookup_set_i   = v.set;
    hit_vec_i      = v.hv;
    tick();
    lookup_valid_i = 1'b0;
    hit_vec_i      = '0;
    chk("ready_low_busy", lookup_ready_o, 0);
    if ($countones(v.hv) >= 2) begin
      chk("inval_valid", inval_valid_o, 1);
      chk("inval_set", inval_set_o, v.set);
      chk("inval_ways", inval_ways_o, v.exp_inval);
      chk("cnt_at_inval", multihit_cnt_o, v.exp_cnt);
      for (int i = 0; i < v.inv_dly; i++) begin
        tick();
        chk("inval_held", inval_valid_o, 1);
      end
      inval_ack_i = 1'b1;
      tick();
      inval_ack_i = 1'b0;
    end
    if (!v.exp_hit) begin
      chk("refill_req", refill_req_o, 1);
      chk("refill_set", refill_set_o, v.set);
      chk("refill_way", refill_way_o, v.exp_way);
      for (int i = 0; i < v.ref_dly; i++) begin
        tick();
        chk("refill_req_held", refill_req_o, 1);
        chk("refill_way_stable", refill_way_o, v.exp_way);
      end
      refill_ack_i = 1'b1;
      tick();
      refill_ack_i = 1'b0;
    end
    chk("resp_valid", resp_valid_o, 1);
    chk("resp_hit", resp_hit_o, v.exp_hit);
    chk("resp_way", resp_way_o, v.exp_way);
    for (int i = 0; i < v.rsp_dly; i++) begin
      tick();
      chk("resp_valid_held", resp_valid_o, 1);
      chk("resp_hit_stable", resp_hit_o, v.exp_hit);
      chk("resp_way_stable", resp_way_o, v.exp_way);
      chk("ready_low_in_resp", lookup_ready_o, 0);
    end
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("resp_valid_cleared", resp_valid_o, 0);
    chk("ready_after_handshake", lookup_ready_o, 1);
    chk("multihit_cnt", multihit_cnt_o, v.exp_cnt);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   cnt;

    rst_n          = 1'b0;
    lookup_valid_i = 1'b0;
    lookup_set_i   = '0;
    hit_vec_i      = '0;
    resp_ready_i   = 1'b0;
    inval_ack_i    = 1'b0;
    refill_ack_i   = 1'b0;

    //        set    hv       inv ref rsp hit   way   inval    cnt
    tbl.push_back('{6'd5,  4'b0100, 0, 0, 0, 1'b1, 2'd2, 4'b0000, 8'd0});
    tbl.push_back('{6'd3,  4'b0000, 0, 2, 0, 1'b0, 2'd0, 4'b0000, 8'd0});
    tbl.push_back('{6'd3,  4'b0000, 0, 2, 0, 1'b0, 2'd1, 4'b0000, 8'd0});
    tbl.push_back('{6'd3,  4'b0000, 0, 2, 0, 1'b0, 2'd2, 4'b0000, 8'd0});
    tbl.push_back('{6'd3,  4'b0000, 0, 2, 0, 1'b0, 2'd3, 4'b0000, 8'd0});
    tbl.push_back('{6'd3,  4'b0000, 0, 2, 0, 1'b0, 2'd0, 4'b0000, 8'd0});
    tbl.push_back('{6'd7,  4'b1010, 1, 1, 0, 1'b0, 2'd0, 4'b1010, 8'd1});
    tbl.push_back('{6'd5,  4'b0000, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 8'd1});
    tbl.push_back('{6'd7,  4'b0000, 0, 1, 0, 1'b0, 2'd1, 4'b0000, 8'd1});
    tbl.push_back('{6'd3,  4'b1000, 0, 0, 4, 1'b1, 2'd3, 4'b0000, 8'd1});
    tbl.push_back('{6'd3,  4'b0000, 0, 0, 0, 1'b0, 2'd1, 4'b0000, 8'd1});
    tbl.push_back('{6'd0,  4'b1111, 0, 0, 0, 1'b0, 2'd0, 4'b1111, 8'd2});
    tbl.push_back('{6'd63, 4'b0001, 0, 0, 0, 1'b1, 2'd0, 4'b0000, 8'd2});
    tbl.push_back('{6'd63, 4'b0010, 0, 0, 1, 1'b1, 2'd1, 4'b0000, 8'd2});
    tbl.push_back('{6'd0,  4'b0110, 3, 2, 0, 1'b0, 2'd1, 4'b0110, 8'd3});
    tbl.push_back('{6'd0,  4'b0000, 0, 0, 0, 1'b0, 2'd2, 4'b0000, 8'd3});

    #1;
    chk("rst_lookup_ready", lookup_ready_o, 1);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_hit", resp_hit_o, 0);
    chk("rst_resp_way", resp_way_o, 0);
    chk("rst_inval_valid", inval_valid_o, 0);
    chk("rst_inval_ways", inval_ways_o, 0);
    chk("rst_refill_req", refill_req_o, 0);
    chk("rst_cnt", multihit_cnt_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) run(tbl[i]);

    // Saturation: 300 multi-hits on set 9 (pointer starts at 0, counter at 3).
    cnt = 3;
    for (int k = 0; k < 300; k++) begin
      cnt = (cnt < 255) ? cnt + 1 : 255;
      v = '{6'd9, 4'b0011, 0, 0, 0, 1'b0, 2'(k % 4), 4'b0011, 8'(cnt)};
      run(v);
    end
    chk("cnt_saturated", multihit_cnt_o, 255);

    // Reset in the middle of a refill abandons the lookup.
    lookup_valid_i = 1'b1;
    lookup_set_i   = 6'd10;
    hit_vec_i      = 4'b0000;
    tick();
    lookup_valid_i = 1'b0;
    chk("pre_reset_refill_req", refill_req_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_refill_req", refill_req_o, 0);
    chk("async_rst_lookup_ready", lookup_ready_o, 1);
    chk("async_rst_resp_valid", resp_valid_o, 0);
    chk("async_rst_cnt", multihit_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Acks outside their states must not move anything.
    refill_ack_i = 1'b1;
    inval_ack_i  = 1'b1;
    tick();
    tick();
    refill_ack_i = 1'b0;
    inval_ack_i  = 1'b0;
    chk("stray_ack_idle", lookup_ready_o, 1);
    chk("stray_ack_no_resp", resp_valid_o, 0);

    run('{6'd3,  4'b0000, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 8'd0});
    run('{6'd10, 4'b0000, 0, 1, 0, 1'b0, 2'd0, 4'b0000, 8'd0});
    run('{6'd3,  4'b0101, 2, 0, 2, 1'b0, 2'd1, 4'b0101, 8'd1});
    run('{6'd9,  4'b0000, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 8'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
